// File: rtl/alu_op_sequencer_pkg.sv
// alu_seq_pkg: shared definitions for the phase-1 datapath control sequencer.
//   - opcode constants for the supported instruction set
//   - FSM state and instruction-class enumerations
//   - IR field bit positions
//   - field_ok(): register-field range check against the configured register count
package alu_seq_pkg;

   localparam int IR_W   = 32;
   localparam int FLD_W  = 4;
   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   localparam logic [4:0] OP_ADD = 5'd3;
   localparam logic [4:0] OP_SUB = 5'd4;
   localparam logic [4:0] OP_AND = 5'd5;
   localparam logic [4:0] OP_OR  = 5'd6;
   localparam logic [4:0] OP_MUL = 5'd15;
   localparam logic [4:0] OP_DIV = 5'd16;
   localparam logic [4:0] OP_NEG = 5'd17;
   localparam logic [4:0] OP_NOT = 5'd18;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
   } state_e;

   typedef enum logic [1:0] {
      CLS_BIN, CLS_UNA, CLS_MULDIV, CLS_ILL
   } class_e;

   function automatic logic field_ok(input logic [FLD_W-1:0] f, input int unsigned nregs);
      return ({{(32-FLD_W){1'b0}}, f} < nregs);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_ir_decoder.sv
// ir_decoder: combinational instruction classifier.
//   ir_i       : IR contents
//   cls_o      : instruction class (binary / unary / muldiv / illegal)
//   ra_o/rb_o/rc_o : register fields
//   illegal_o  : unknown opcode, or a used register field >= NUM_REGS
module ir_decoder
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic [IR_W-1:0]  ir_i,
   output class_e           cls_o,
   output logic [FLD_W-1:0] ra_o,
   output logic [FLD_W-1:0] rb_o,
   output logic [FLD_W-1:0] rc_o,
   output logic             illegal_o
);

   logic [4:0] opc;
   logic       unused_low_bits;

   assign opc = ir_i[OPC_LSB +: 5];
   assign ra_o = ir_i[RA_LSB +: FLD_W];
   assign rb_o = ir_i[RB_LSB +: FLD_W];
   assign rc_o = ir_i[RC_LSB +: FLD_W];
   // Immediate/low bits carry nothing for this instruction set.
   assign unused_low_bits = ^ir_i[RC_LSB-1:0];

   always_comb begin
      cls_o = CLS_ILL;
      case (opc)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            if (field_ok(ra_o, NUM_REGS) && field_ok(rb_o, NUM_REGS) && field_ok(rc_o, NUM_REGS))
               cls_o = CLS_BIN;
         end
         OP_MUL, OP_DIV: begin
            if (field_ok(ra_o, NUM_REGS) && field_ok(rb_o, NUM_REGS))
               cls_o = CLS_MULDIV;
         end
         OP_NEG, OP_NOT: begin
            if (field_ok(ra_o, NUM_REGS) && field_ok(rb_o, NUM_REGS))
               cls_o = CLS_UNA;
         end
         default: cls_o = CLS_ILL;
      endcase
   end

   assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: per-instruction control FSM for the phase-1 datapath.
// Runs fetch (T0..T2, with T1W stalling on mem_rdy), then an execute sequence
// selected by opcode class, and drives the datapath strobes as registered
// Moore outputs.
//   clock, clear      : clock and synchronous active-low reset
//   start             : begin one instruction (honoured only in IDLE)
//   mem_rdy           : memory data valid during fetch
//   ir                : current IR contents, decoded at the T2->T3 edge
//   pc_*/mar_in/read/mdr_*/ir_in/y_in/z*/lo_in/hi_in : datapath strobes
//   reg_in, reg_out   : one-hot register enables
//   alu_op            : opcode to the ALU, non-zero only alongside zlo_in in execute
//   busy, done, illegal : status
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OPC_W    = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic                mem_rdy,
   input  logic [IR_W-1:0]     ir,
   output logic                pc_out,
   output logic                pc_in,
   output logic                inc_pc,
   output logic                mar_in,
   output logic                read,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic                zlo_in,
   output logic                zhi_in,
   output logic                zlo_out,
   output logic                zhi_out,
   output logic                lo_in,
   output logic                hi_in,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [OPC_W-1:0]    alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   typedef struct packed {
      logic                pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in;
      logic                zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
      logic [NUM_REGS-1:0] reg_in, reg_out;
      logic [OPC_W-1:0]    alu_op;
      logic                busy, done, illegal;
   } outs_t;

   localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   outs_t            outs_q, outs_d;
   class_e           cls_q, cls_n, dec_cls;
   logic             ill_q, ill_n, dec_ill;
   logic [FLD_W-1:0] ra_q, rb_q, rc_q, ra_n, rb_n, rc_n;
   logic [FLD_W-1:0] dec_ra, dec_rb, dec_rc;
   logic [OPC_W-1:0] opc_q, opc_n;

   ir_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
      .ir_i      (ir),
      .cls_o     (dec_cls),
      .ra_o      (dec_ra),
      .rb_o      (dec_rb),
      .rc_o      (dec_rc),
      .illegal_o (dec_ill)
   );

   // The T3 outputs are built while still in T2, so they must see the
   // decoder directly; from T3 on the latched copy is used.
   always_comb begin
      if (state_q == S_T2) begin
         cls_n = dec_cls;
         ill_n = dec_ill;
         ra_n  = dec_ra;
         rb_n  = dec_rb;
         rc_n  = dec_rc;
         opc_n = ir[IR_W-1 -: OPC_W];
      end else begin
         cls_n = cls_q;
         ill_n = ill_q;
         ra_n  = ra_q;
         rb_n  = rb_q;
         rc_n  = rc_q;
         opc_n = opc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (start) state_d = S_T0;
         S_T0:         state_d = S_T1;
         S_T1, S_T1W:  state_d = mem_rdy ? S_T2 : S_T1W;
         S_T2:         state_d = S_T3;
         S_T3:         state_d = ill_q ? S_DONE : S_T4;
         S_T4:         state_d = (cls_q == CLS_UNA) ? S_DONE : S_T5;
         S_T5:         state_d = (cls_q == CLS_BIN) ? S_DONE : S_T6;
         S_T6:         state_d = S_DONE;
         S_DONE:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // Output decode of the next state, registered with it.
   always_comb begin
      outs_d      = '0;
      outs_d.busy = (state_d != S_IDLE);
      case (state_d)
         S_T0: begin
            outs_d.pc_out = 1'b1;
            outs_d.mar_in = 1'b1;
            outs_d.inc_pc = 1'b1;
            outs_d.zlo_in = 1'b1;
         end
         S_T1: begin
            outs_d.zlo_out = 1'b1;
            outs_d.pc_in   = 1'b1;
            outs_d.read    = 1'b1;
            outs_d.mdr_in  = 1'b1;
         end
         S_T1W: begin
            outs_d.read   = 1'b1;
            outs_d.mdr_in = 1'b1;
         end
         S_T2: begin
            outs_d.mdr_out = 1'b1;
            outs_d.ir_in   = 1'b1;
         end
         S_T3: begin
            if (ill_n) begin
               outs_d.illegal = 1'b1;
            end else begin
               case (cls_n)
                  CLS_BIN: begin
                     outs_d.reg_out = ONE_HOT0 << rb_n;
                     outs_d.y_in    = 1'b1;
                  end
                  CLS_UNA: begin
                     outs_d.reg_out = ONE_HOT0 << rb_n;
                     outs_d.zlo_in  = 1'b1;
                     outs_d.alu_op  = opc_n;
                  end
                  default: begin
                     outs_d.reg_out = ONE_HOT0 << ra_n;
                     outs_d.y_in    = 1'b1;
                  end
               endcase
            end
         end
         S_T4: begin
            case (cls_n)
               CLS_BIN: begin
                  outs_d.reg_out = ONE_HOT0 << rc_n;
                  outs_d.zlo_in  = 1'b1;
                  outs_d.alu_op  = opc_n;
               end
               CLS_UNA: begin
                  outs_d.zlo_out = 1'b1;
                  outs_d.reg_in  = ONE_HOT0 << ra_n;
               end
               default: begin
                  outs_d.reg_out = ONE_HOT0 << rb_n;
                  outs_d.zlo_in  = 1'b1;
                  outs_d.zhi_in  = 1'b1;
                  outs_d.alu_op  = opc_n;
               end
            endcase
         end
         S_T5: begin
            outs_d.zlo_out = 1'b1;
            if (cls_n == CLS_BIN) outs_d.reg_in = ONE_HOT0 << ra_n;
            else                  outs_d.lo_in  = 1'b1;
         end
         S_T6: begin
            outs_d.zhi_out = 1'b1;
            outs_d.hi_in   = 1'b1;
         end
         S_DONE:  outs_d.done = 1'b1;
         default: outs_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= S_IDLE;
         outs_q  <= '0;
      end else begin
         state_q <= state_d;
         outs_q  <= outs_d;
         if (state_q == S_T2) begin
            cls_q <= dec_cls;
            ill_q <= dec_ill;
            ra_q  <= dec_ra;
            rb_q  <= dec_rb;
            rc_q  <= dec_rc;
            opc_q <= ir[IR_W-1 -: OPC_W];
         end
      end
   end

   assign pc_out  = outs_q.pc_out;
   assign pc_in   = outs_q.pc_in;
   assign inc_pc  = outs_q.inc_pc;
   assign mar_in  = outs_q.mar_in;
   assign read    = outs_q.read;
   assign mdr_in  = outs_q.mdr_in;
   assign mdr_out = outs_q.mdr_out;
   assign ir_in   = outs_q.ir_in;
   assign y_in    = outs_q.y_in;
   assign zlo_in  = outs_q.zlo_in;
   assign zhi_in  = outs_q.zhi_in;
   assign zlo_out = outs_q.zlo_out;
   assign zhi_out = outs_q.zhi_out;
   assign lo_in   = outs_q.lo_in;
   assign hi_in   = outs_q.hi_in;
   assign reg_in  = outs_q.reg_in;
   assign reg_out = outs_q.reg_out;
   assign alu_op  = outs_q.alu_op;
   assign busy    = outs_q.busy;
   assign done    = outs_q.done;
   assign illegal = outs_q.illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: two instances (16 and 8 registers) share the
// same stimulus and are compared every cycle against a strobe-list model.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in;
      logic zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
      logic [15:0] reg_in, reg_out;
      logic [4:0]  alu_op;
      logic busy, done, illegal;
   } outs_t;

   typedef struct packed {
      outs_t o;
      logic  wt;   // cycle that waits for mem_rdy
      logic  dec;  // last fetch cycle: instruction decoded on leaving it
   } ent_t;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        mem_rdy = 1'b1;
   logic [31:0] ir = 32'h0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   logic a_pc_out, a_pc_in, a_inc_pc, a_mar_in, a_read, a_mdr_in, a_mdr_out, a_ir_in, a_y_in;
   logic a_zlo_in, a_zhi_in, a_zlo_out, a_zhi_out, a_lo_in, a_hi_in, a_busy, a_done, a_illegal;
   logic [15:0] a_reg_in, a_reg_out;
   logic [4:0]  a_alu_op;
   logic b_pc_out, b_pc_in, b_inc_pc, b_mar_in, b_read, b_mdr_in, b_mdr_out, b_ir_in, b_y_in;
   logic b_zlo_in, b_zhi_in, b_zlo_out, b_zhi_out, b_lo_in, b_hi_in, b_busy, b_done, b_illegal;
   logic [7:0]  b_reg_in, b_reg_out;
   logic [4:0]  b_alu_op;

   alu_op_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut16 (
      .clock(clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
      .pc_out(a_pc_out), .pc_in(a_pc_in), .inc_pc(a_inc_pc), .mar_in(a_mar_in),
      .read(a_read), .mdr_in(a_mdr_in), .mdr_out(a_mdr_out), .ir_in(a_ir_in), .y_in(a_y_in),
      .zlo_in(a_zlo_in), .zhi_in(a_zhi_in), .zlo_out(a_zlo_out), .zhi_out(a_zhi_out),
      .lo_in(a_lo_in), .hi_in(a_hi_in), .reg_in(a_reg_in), .reg_out(a_reg_out),
      .alu_op(a_alu_op), .busy(a_busy), .done(a_done), .illegal(a_illegal)
   );

   alu_op_sequencer #(.NUM_REGS(8), .OPC_W(5)) dut8 (
      .clock(clock), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
      .pc_out(b_pc_out), .pc_in(b_pc_in), .inc_pc(b_inc_pc), .mar_in(b_mar_in),
      .read(b_read), .mdr_in(b_mdr_in), .mdr_out(b_mdr_out), .ir_in(b_ir_in), .y_in(b_y_in),
      .zlo_in(b_zlo_in), .zhi_in(b_zhi_in), .zlo_out(b_zlo_out), .zhi_out(b_zhi_out),
      .lo_in(b_lo_in), .hi_in(b_hi_in), .reg_in(b_reg_in), .reg_out(b_reg_out),
      .alu_op(b_alu_op), .busy(b_busy), .done(b_done), .illegal(b_illegal)
   );

   outs_t g16, g8;
   assign g16 = {a_pc_out, a_pc_in, a_inc_pc, a_mar_in, a_read, a_mdr_in, a_mdr_out, a_ir_in, a_y_in,
                 a_zlo_in, a_zhi_in, a_zlo_out, a_zhi_out, a_lo_in, a_hi_in,
                 a_reg_in, a_reg_out, a_alu_op, a_busy, a_done, a_illegal};
   assign g8  = {b_pc_out, b_pc_in, b_inc_pc, b_mar_in, b_read, b_mdr_in, b_mdr_out, b_ir_in, b_y_in,
                 b_zlo_in, b_zhi_in, b_zlo_out, b_zhi_out, b_lo_in, b_hi_in,
                 {8'h00, b_reg_in}, {8'h00, b_reg_out}, b_alu_op, b_busy, b_done, b_illegal};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model: per-instruction strobe lists ----------------
   ent_t cur [2];
   ent_t seq [2][16];
   int   len [2];
   int   pos [2];

   function automatic ent_t busy_ent();
      ent_t e = '0;
      e.o.busy = 1'b1;
      return e;
   endfunction

   task automatic push(input int m, input ent_t e);
      seq[m][len[m]] = e;
      len[m]++;
   endtask

   task automatic push_exec(input int m, input int nregs, input logic [31:0] iv);
      int opc = int'(iv[31:27]);
      int ra  = int'(iv[26:23]);
      int rb  = int'(iv[22:19]);
      int rc  = int'(iv[18:15]);
      bit bin = (opc >= 3 && opc <= 6);
      bit md  = (opc == 15 || opc == 16);
      bit un  = (opc == 17 || opc == 18);
      bit ok  = (bin && ra < nregs && rb < nregs && rc < nregs) ||
                ((md || un) && ra < nregs && rb < nregs);
      ent_t e;
      if (!ok) begin
         e = busy_ent(); e.o.illegal = 1; push(m, e);
      end else if (bin) begin
         e = busy_ent(); e.o.reg_out = 16'h1 << rb; e.o.y_in = 1; push(m, e);
         e = busy_ent(); e.o.reg_out = 16'h1 << rc; e.o.zlo_in = 1; e.o.alu_op = 5'(opc); push(m, e);
         e = busy_ent(); e.o.zlo_out = 1; e.o.reg_in = 16'h1 << ra; push(m, e);
      end else if (un) begin
         e = busy_ent(); e.o.reg_out = 16'h1 << rb; e.o.zlo_in = 1; e.o.alu_op = 5'(opc); push(m, e);
         e = busy_ent(); e.o.zlo_out = 1; e.o.reg_in = 16'h1 << ra; push(m, e);
      end else begin
         e = busy_ent(); e.o.reg_out = 16'h1 << ra; e.o.y_in = 1; push(m, e);
         e = busy_ent(); e.o.reg_out = 16'h1 << rb; e.o.zlo_in = 1; e.o.zhi_in = 1;
         e.o.alu_op = 5'(opc); push(m, e);
         e = busy_ent(); e.o.zlo_out = 1; e.o.lo_in = 1; push(m, e);
         e = busy_ent(); e.o.zhi_out = 1; e.o.hi_in = 1; push(m, e);
      end
      e = busy_ent(); e.o.done = 1; push(m, e);
   endtask

   task automatic model_step(input int m, input int nregs);
      ent_t e;
      if (!clear) begin
         cur[m] = '0; len[m] = 0; pos[m] = 0;
      end else if (cur[m].o.busy !== 1'b1) begin
         cur[m] = '0;
         if (start) begin
            len[m] = 0;
            e = busy_ent(); e.o.pc_out = 1; e.o.mar_in = 1; e.o.inc_pc = 1; e.o.zlo_in = 1; push(m, e);
            e = busy_ent(); e.o.zlo_out = 1; e.o.pc_in = 1; e.o.read = 1; e.o.mdr_in = 1; e.wt = 1; push(m, e);
            e = busy_ent(); e.o.mdr_out = 1; e.o.ir_in = 1; e.dec = 1; push(m, e);
            cur[m] = seq[m][0];
            pos[m] = 1;
         end
      end else if (cur[m].wt && !mem_rdy) begin
         e = busy_ent(); e.o.read = 1; e.o.mdr_in = 1; e.wt = 1;
         cur[m] = e;
      end else begin
         if (cur[m].dec) push_exec(m, nregs, ir);
         if (pos[m] < len[m]) begin
            cur[m] = seq[m][pos[m]];
            pos[m]++;
         end else begin
            cur[m] = '0;
         end
      end
   endtask

   always @(posedge clock) begin
      model_step(0, 16);
      model_step(1, 8);
   end

   function automatic bit bus_ok(input outs_t o);
      int n = int'(o.pc_out) + int'(o.mdr_out) + int'(o.zlo_out) + int'(o.zhi_out) +
              int'(o.reg_out != 16'h0);
      return (n <= 1) && $onehot0(o.reg_out) && $onehot0(o.reg_in);
   endfunction

   always @(negedge clock) begin
      check_val("cyc16", 64'(g16), 64'(cur[0].o));
      check_val("cyc8",  64'(g8),  64'(cur[1].o));
      check_val("bus16", 64'(bus_ok(g16)), 64'd1);
      check_val("bus8",  64'(bus_ok(g8)),  64'd1);
   end

   // ---------------- directed instruction runner ----------------
   // Cycle numbering: T0 is cycle 1. Records first done/illegal cycle per DUT.
   task automatic run_instr(input string tag, input logic [31:0] irv, input bit stall,
                            input int spulse, input int exp_d16, input int exp_d8,
                            input int exp_i16, input int exp_i8);
      int d16 = 0, d8 = 0, i16 = 0, i8 = 0;
      ir = irv; start = 1'b1; mem_rdy = 1'b1;
      for (int n = 1; n <= 40 && (d16 == 0 || d8 == 0); n++) begin
         @(negedge clock);
         if (a_done && d16 == 0) d16 = n;
         if (b_done && d8 == 0)  d8  = n;
         if (a_illegal && i16 == 0) i16 = n;
         if (b_illegal && i8 == 0)  i8  = n;
         mem_rdy = !(stall && n >= 2 && n <= 4);
         start   = (n == spulse);
      end
      start = 1'b0; mem_rdy = 1'b1;
      check_val({tag, "_done16"}, 64'(d16), 64'(exp_d16));
      check_val({tag, "_done8"},  64'(d8),  64'(exp_d8));
      check_val({tag, "_ill16"},  64'(i16), 64'(exp_i16));
      check_val({tag, "_ill8"},   64'(i8),  64'(exp_i8));
      @(negedge clock);
      check_val({tag, "_idle16"}, 64'(a_busy), 64'd0);
   endtask

   initial begin
      int ndone;
      int cyc;
      logic [4:0] opc_tab [8];
      opc_tab[0] = 5'd3;  opc_tab[1] = 5'd4;  opc_tab[2] = 5'd5;  opc_tab[3] = 5'd6;
      opc_tab[4] = 5'd15; opc_tab[5] = 5'd16; opc_tab[6] = 5'd17; opc_tab[7] = 5'd18;

      // reset state
      start = 1'b1;
      repeat (3) @(negedge clock);
      check_val("reset16", 64'(g16), 64'd0);
      check_val("reset8",  64'(g8),  64'd0);
      start = 1'b0;
      clear = 1'b1;
      @(negedge clock);

      run_instr("add",    32'h19A38000, 1'b0, 0, 7, 7, 0, 0);
      run_instr("not",    32'h922B8000, 1'b0, 0, 6, 6, 0, 0);
      run_instr("mul",    32'h79B80000, 1'b1, 0, 11, 11, 0, 0);
      run_instr("badop",  32'hF8000000, 1'b0, 0, 5, 5, 4, 4);
      run_instr("addrc12",32'h19A60000, 1'b0, 0, 7, 5, 0, 4);
      // start pulse while in T4 must not launch another instruction
      run_instr("bsyst",  32'h19A38000, 1'b0, 5, 7, 7, 0, 0);

      // reset while stalled in T1W
      ir = 32'h79B80000; start = 1'b1; mem_rdy = 1'b0;
      @(negedge clock); start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check_val("t1w_read", 64'(a_read & a_mdr_in & a_busy), 64'd1);
      clear = 1'b0;
      @(negedge clock);
      check_val("midrst16", 64'(g16), 64'd0);
      check_val("midrst8",  64'(g8),  64'd0);
      clear = 1'b1; mem_rdy = 1'b1;
      run_instr("postrst", 32'h19A38000, 1'b0, 0, 7, 7, 0, 0);

      // randomized instructions with random start/mem_rdy/clear activity
      ndone = 0;
      cyc = 0;
      while (ndone < 100 && cyc < 20000) begin
         logic [4:0] opc;
         opc = ($urandom_range(0, 9) < 8) ? opc_tab[$urandom_range(0, 7)] : 5'($urandom);
         ir      = {opc, 27'($urandom)};
         start   = ($urandom_range(0, 1) == 1);
         mem_rdy = ($urandom_range(0, 3) != 0);
         clear   = ($urandom_range(0, 99) != 0);
         @(negedge clock);
         if (a_done) ndone++;
         cyc++;
      end
      clear = 1'b1; start = 1'b0;
      check_val("rand_count", 64'(ndone >= 100), 64'd1);
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardware control sequencer for the phase-1 datapath. It replaces the hand-written per-instruction testbench state machines with one parametrised FSM. Each instruction runs fetch (T0–T2), then an execute sequence chosen by opcode class: binary register ALU, unary (neg/not), or mul/div with HI/LO writeback. It drives the datapath's one-hot bus/register strobes, waits on a memory-ready handshake during fetch, and flags illegal instructions.

## Interface
Parameters:
- NUM_REGS, 16, general registers driven by reg_in/reg_out (2..16).
- OPC_W, 5, opcode field width (IR[31:27]).

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  reset, synchronous and active-low.
- start  in  1  begin one instruction; sampled only in IDLE.
- mem_rdy  in  1  memory read data valid on Mdatain.
- ir  in  32  current IR register contents.
- pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  datapath strobes.
- zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in  out  1 each  Z/HI/LO strobes.
- reg_in, reg_out  out  NUM_REGS  one-hot register enables.
- alu_op  out  OPC_W  opcode to ALU; valid only with zlo_in.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at instruction end.
- illegal  out  1  one-cycle pulse on undecodable instruction.

## Operation
- IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Opcodes: ADD=3, SUB=4, AND=5, OR=6 (binary); MUL=15, DIV=16 (muldiv); NEG=17, NOT=18 (unary). All other opcodes are illegal. Any used register field ≥ NUM_REGS is also illegal.
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, DONE. Outputs are Moore decode of the state plus the latched class and fields.
- T0: pc_out, mar_in, inc_pc, zlo_in.
- T1: zlo_out, pc_in, read, mdr_in. Go to T2 if mem_rdy, else T1W.
- T1W: read, mdr_in held. Stay while !mem_rdy.
- T2: mdr_out, ir_in.
- At the T2→T3 edge, decode the ir input (it is valid from T3 onward) and latch class and fields.
- Binary:
  - T3: reg_out[Rb], y_in.
  - T4: reg_out[Rc], zlo_in, alu_op.
  - T5: zlo_out, reg_in[Ra].
  - Then DONE.
- Unary:
  - T3: reg_out[Rb], zlo_in, alu_op.
  - T4: zlo_out, reg_in[Ra].
  - Then DONE.
- Muldiv:
  - T3: reg_out[Ra], y_in.
  - T4: reg_out[Rb], zlo_in, zhi_in, alu_op.
  - T5: zlo_out, lo_in.
  - T6: zhi_out, hi_in.
  - Then DONE.
- Illegal: illegal=1 in T3 with no strobes, then DONE.
- DONE: done=1, then IDLE.
- Only one bus driver (*_out, reg_out) may be active in any cycle.
- reg_in and reg_out are zero or one-hot.

## Timing
- Reset: clear low at an edge puts the FSM in IDLE. All outputs are 0 in the next cycle, including alu_op=0, busy=0 and any in-flight done/illegal. This holds mid-instruction, including T1W.
- start high at edge k enters T0 at edge k. start is ignored while busy.
- With mem_rdy already high, done is asserted N cycles after T0 entry (T0 = cycle 1):
  - binary: N=7
  - unary: N=6
  - muldiv: N=8
  - illegal: N=5
- Each cycle in T1W adds one cycle.
- start high during DONE is ignored. A new instruction needs start in IDLE, so the minimum gap between instructions is 1 cycle.
- mem_rdy outside T1/T1W is ignored.

## Structure
- Package alu_seq_pkg:
  - opcode constants
  - state enum
  - class enum (BIN, UNA, MULDIV, ILL)
  - field bit positions
- Sub-module ir_decoder (combinational): takes ir and NUM_REGS, returns class, Ra/Rb/Rc and illegal. The FSM registers its outputs at the T2→T3 edge.

## Test plan
- ADD R3,R4,R7: ir=0x19A38000, mem_rdy tied high.
  - T3: reg_out=0x0010, y_in.
  - T4: reg_out=0x0080, zlo_in, alu_op=3.
  - T5: reg_in=0x0008, zlo_out.
  - done in cycle 7.
- NOT R4,R5: ir=0x922B8000.
  - T3: reg_out=0x0020, alu_op=18, zlo_in.
  - T4: reg_in=0x0010.
  - done in cycle 6.
- MUL R3,R7: ir=0x79B80000, mem_rdy low for 3 cycles in fetch.
  - T1W lasts 3 cycles, read/mdr_in held.
  - T4: zlo_in and zhi_in together.
  - T5: lo_in; T6: hi_in.
  - done in cycle 11.
- Illegal: ir=0xF8000000 → illegal pulse in cycle 4, no reg_in ever asserted, done in cycle 5. With NUM_REGS=8, ADD with Rc=12 also yields illegal.
- Reset mid-op: clear low in T1W → IDLE, all outputs 0 next cycle. start afterwards runs a clean fetch.
- Start while busy: a start pulse in T4 is ignored. The next instruction begins only from a start issued in IDLE. Check that the one-hot bus-driver assertion holds over 100 random instructions.
